// File: rtl/inv_sub_bytes.sv
// AES InvSubBytes stage: column-serial by default (4 cycles/block); define ISB_PARALLEL_EN
// for a single-cycle, 16-port variant. The inverse S-box table is built at elaboration.
module inv_sub_bytes #(
  parameter INV_SBOX_FILE = "inv_sbox.mem"
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         En_ISB,
  input  logic [127:0] In_ISB,
  output logic         Ry_ISB,
  output logic         Busy_ISB,
  output logic [127:0] Out_ISB
);

  localparam int unsigned BLK_W  = 128;
  localparam int unsigned COL_W  = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned TBL_W  = 256 * BYTE_W;

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
  function automatic logic [BYTE_W-1:0] gf_mul(input logic [BYTE_W-1:0] a_in,
                                               input logic [BYTE_W-1:0] b);
    logic [BYTE_W-1:0] a;
    logic [BYTE_W-1:0] p;
    a = a_in;
    p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0)
  function automatic logic [BYTE_W-1:0] gf_inv(input logic [BYTE_W-1:0] x);
    logic [BYTE_W-1:0] r;
    logic [BYTE_W-1:0] e;
    r = 8'h01;
    e = 8'd254;
    for (int i = 7; i >= 0; i--) begin
      r = gf_mul(r, r);
      if (e[i]) r = gf_mul(r, x);
    end
    return r;
  endfunction

  // Inverse S-box: undo the affine map, then invert in GF(2^8)
  function automatic logic [TBL_W-1:0] build_rom();
    logic [TBL_W-1:0]  tbl;
    logic [BYTE_W-1:0] s;
    logic [BYTE_W-1:0] a;
    tbl = '0;
    for (int i = 0; i < 256; i++) begin
      s = BYTE_W'(i);
      a = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
      tbl[i*BYTE_W +: BYTE_W] = gf_inv(a);
    end
    return tbl;
  endfunction

  localparam logic [TBL_W-1:0] INV_SBOX = build_rom();

  function automatic logic [BYTE_W-1:0] inv_s(input logic [BYTE_W-1:0] b);
    return INV_SBOX[{b, 3'b000} +: BYTE_W];
  endfunction

  function automatic logic [COL_W-1:0] sub_word(input logic [COL_W-1:0] w);
    return {inv_s(w[31:24]), inv_s(w[23:16]), inv_s(w[15:8]), inv_s(w[7:0])};
  endfunction

`ifdef ISB_PARALLEL_EN

  logic [BLK_W-1:0] sub_all;

  always_comb begin
    sub_all = {sub_word(In_ISB[127:96]), sub_word(In_ISB[95:64]),
               sub_word(In_ISB[63:32]),  sub_word(In_ISB[31:0])};
  end

  // Result and ready follow each sampled request by one edge
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      Out_ISB <= '0;
      Ry_ISB  <= 1'b0;
    end else begin
      Ry_ISB <= En_ISB;
      if (En_ISB) Out_ISB <= sub_all;
    end
  end

  assign Busy_ISB = 1'b0;

`else

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [1:0]       col_q, col_d;
  logic [BLK_W-1:0] in_q, in_d;
  logic [BLK_W-1:0] part_q, part_d;
  logic [BLK_W-1:0] out_q, out_d;
  logic             ry_q, ry_d;
  logic             busy_q, busy_d;
  logic [COL_W-1:0] col_in;
  logic [COL_W-1:0] col_sub;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= IDLE;
      col_q   <= '0;
      in_q    <= '0;
      part_q  <= '0;
      out_q   <= '0;
      ry_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      in_q    <= in_d;
      part_q  <= part_d;
      out_q   <= out_d;
      ry_q    <= ry_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    in_d    = in_q;
    part_d  = part_q;
    out_d   = out_q;
    ry_d    = 1'b0;
    busy_d  = busy_q;
    col_in  = in_q[127:96];
    case (col_q)
      2'd0: col_in = in_q[127:96];
      2'd1: col_in = in_q[95:64];
      2'd2: col_in = in_q[63:32];
      2'd3: col_in = in_q[31:0];
      default: col_in = in_q[127:96];
    endcase
    col_sub = sub_word(col_in);

    case (state_q)
      IDLE: begin
        if (En_ISB) begin
          in_d    = In_ISB;
          col_d   = 2'd0;
          state_d = BUSY;
          busy_d  = 1'b1;
        end
      end
      BUSY: begin
        case (col_q)
          2'd0: part_d[127:96] = col_sub;
          2'd1: part_d[95:64]  = col_sub;
          2'd2: part_d[63:32]  = col_sub;
          2'd3: part_d[31:0]   = col_sub;
          default: part_d = part_q;
        endcase
        // Last column: publish the whole block at once
        if (col_q == 2'd3) begin
          out_d   = {part_q[127:32], col_sub};
          ry_d    = 1'b1;
          busy_d  = 1'b0;
          col_d   = 2'd0;
          state_d = IDLE;
        end else begin
          col_d = col_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign Out_ISB  = out_q;
  assign Ry_ISB   = ry_q;
  assign Busy_ISB = busy_q;

`endif

endmodule

// File: tb/tb_inv_sub_bytes.sv
// Self-checking bench for inv_sub_bytes: known vectors, control corner cases and a
// random SubBytes -> InvSubBytes round trip against an arithmetic S-box model.
module tb_inv_sub_bytes;

`ifdef ISB_PARALLEL_EN
  localparam int LAT = 0;
  localparam logic BUSY_EXP = 1'b0;
`else
  localparam int LAT = 4;
  localparam logic BUSY_EXP = 1'b1;
`endif

  logic         Clk = 1'b0;
  logic         Rst;
  logic         En_ISB;
  logic [127:0] In_ISB;
  logic         Ry_ISB;
  logic         Busy_ISB;
  logic [127:0] Out_ISB;
  bit           clk_on = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] fwd_sb [256];
  logic [7:0] inv_sb [256];

  inv_sub_bytes dut (
    .Clk(Clk), .Rst(Rst), .En_ISB(En_ISB), .In_ISB(In_ISB),
    .Ry_ISB(Ry_ISB), .Busy_ISB(Busy_ISB), .Out_ISB(Out_ISB)
  );

  always begin
    #5;
    if (clk_on) Clk = ~Clk;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    int acc;
    int x;
    acc = 0;
    x = int'(a);
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = x << 1;
      if (x > 255) x = x ^ 'h11b;
    end
    return 8'(acc);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  // Forward S-box from its definition; inverse obtained by inverting the table
  task automatic build_ref();
    logic [7:0] inv;
    logic [7:0] s;
    for (int i = 0; i < 256; i++) begin
      inv = 8'h00;
      for (int j = 1; j < 256; j++)
        if (ref_mul(8'(i), 8'(j)) == 8'h01) inv = 8'(j);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      fwd_sb[i] = s;
    end
    for (int i = 0; i < 256; i++) inv_sb[fwd_sb[i]] = 8'(i);
  endtask

  function automatic logic [127:0] map_fwd(input logic [127:0] x);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = fwd_sb[x[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] map_inv(input logic [127:0] x);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = inv_sb[x[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One-cycle request, bounded wait for Ry, then latency/result/pulse-width checks
  task automatic run_block(input string tag, input logic [127:0] din, input logic [127:0] exp);
    int lat;
    lat = -1;
    @(negedge Clk);
    In_ISB = din;
    En_ISB = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge Clk);
      En_ISB = 1'b0;
      if (k == 1) check({tag, "_busy"}, 128'(Busy_ISB), 128'(BUSY_EXP));
      if (Ry_ISB) begin
        lat = k - 1;
        break;
      end
    end
    check({tag, "_lat"}, 128'(lat), 128'(LAT));
    if (lat >= 0) begin
      check({tag, "_out"}, Out_ISB, exp);
      @(negedge Clk);
      check({tag, "_pulse"}, 128'(Ry_ISB), 128'(0));
    end
  endtask

  initial begin
    logic [127:0] a;
    logic [127:0] b;
    logic [127:0] seen;
    int           n_ry;

    Rst = 1'b1;
    En_ISB = 1'b0;
    In_ISB = '0;
    #3;
    check("rst_out", Out_ISB, 128'(0));
    check("rst_ry", 128'(Ry_ISB), 128'(0));
    check("rst_busy", 128'(Busy_ISB), 128'(0));

    build_ref();
    check("ref_inv63", 128'(inv_sb[8'h63]), 128'(8'h00));
    clk_on = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b0;

    run_block("fips", 128'h637C777BF26B6FC53001672BFED7AB76,
              128'h000102030405060708090A0B0C0D0E0F);
    run_block("zeros", {16{8'h00}}, {16{8'h52}});
    repeat (3) @(negedge Clk);
    check("hold", Out_ISB, {16{8'h52}});
    run_block("ed", {16{8'hED}}, {16{8'h53}});

`ifndef ISB_PARALLEL_EN
    // Second request and input churn while busy must not disturb the first block
    a = rand128();
    b = rand128();
    @(negedge Clk);
    In_ISB = a;
    En_ISB = 1'b1;
    @(negedge Clk);
    En_ISB = 1'b0;
    @(negedge Clk);
    In_ISB = b;
    En_ISB = 1'b1;
    @(negedge Clk);
    En_ISB = 1'b0;
    In_ISB = ~b;
    n_ry = 0;
    seen = '0;
    for (int k = 0; k < 12; k++) begin
      @(negedge Clk);
      if (Ry_ISB) begin
        n_ry++;
        seen = Out_ISB;
      end
    end
    check("busy_ign_cnt", 128'(n_ry), 128'(1));
    check("busy_ign_out", seen, map_inv(a));

    // Reset two edges into a block aborts it
    @(negedge Clk);
    In_ISB = rand128();
    En_ISB = 1'b1;
    @(negedge Clk);
    En_ISB = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b1;
    #1;
    check("abort_out", Out_ISB, 128'(0));
    check("abort_busy", 128'(Busy_ISB), 128'(0));
    Rst = 1'b0;
    n_ry = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge Clk);
      if (Ry_ISB) n_ry++;
    end
    check("abort_no_ry", 128'(n_ry), 128'(0));
    check("abort_out_hold", Out_ISB, 128'(0));
`else
    // Back-to-back requests: one result and a held Ry per cycle
    @(negedge Clk);
    for (int i = 0; i < 6; i++) begin
      a = rand128();
      In_ISB = a;
      En_ISB = 1'b1;
      @(negedge Clk);
      check("b2b_ry", 128'(Ry_ISB), 128'(1));
      check("b2b_out", Out_ISB, map_inv(a));
    end
    En_ISB = 1'b0;
    @(negedge Clk);
    check("b2b_ry_drop", 128'(Ry_ISB), 128'(0));
    Rst = 1'b1;
    #1;
    check("rst2_out", Out_ISB, 128'(0));
    Rst = 1'b0;
`endif
    a = rand128();
    run_block("after_rst", a, map_inv(a));

    for (int i = 0; i < 1000; i++) begin
      a = rand128();
      run_block("roundtrip", map_fwd(a), a);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
